bram_buffered: RTL and testbench

- Parametrised single-read/single-write block RAM with a credit-limited read-response buffer, byte-masked writes and a selectable read-during-write policy.
- Sits under the scratchpad/cache layers as the successor to the fixed-latency, always-ready BRAM wrapper.
- Gives callers real flow control: reads are accepted only when their response can be held. Responses are held until the consumer dequeues them. noPendingBool reflects actual outstanding reads.

---
 rtl/bram_buffered.sv | 142 ++++++++++++++
 tb/tb_bram_buffered.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_buffered.sv
// Single-read/single-write block RAM with byte-masked writes and an in-order read-response buffer.
// A read is accepted only when its response has a guaranteed slot; responses wait for the consumer.
module bram_buffered #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 9,
   parameter int NUM_ROWS    = 512,
   parameter int OUT_DEPTH   = 2,
   parameter int WRITE_FIRST = 0
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              CLK_GATE,
   input  logic              readEnable,
   input  logic [ADDR_W-1:0] readAddr,
   output logic              readReady,
   output logic [DATA_W-1:0] readData,
   input  logic              readDataEnable,
   output logic              readDataReady,
   input  logic              writeEnable,
   input  logic [ADDR_W-1:0] writeAddr,
   input  logic [DATA_W-1:0] writeData,
   input  logic [DATA_W/8-1:0] writeMask,
   output logic              writeReady,
   output logic              noPendingBool
);
   localparam int NUM_BYTES = DATA_W / 8;
   localparam int FIFO_D    = OUT_DEPTH - 1;
   localparam int FIFO_SZ   = (FIFO_D > 0) ? FIFO_D : 1;
   localparam int PTR_W     = (FIFO_SZ > 1) ? $clog2(FIFO_SZ) : 1;
   localparam int CNT_W     = $clog2(OUT_DEPTH + 1);

   if ((DATA_W % 8) != 0 || OUT_DEPTH < 1 || NUM_ROWS > (2 ** ADDR_W)) begin : gBadParams
      $error("bram_buffered: illegal parameter combination");
   end

   logic [DATA_W-1:0] mem [0:NUM_ROWS-1];
   logic [DATA_W-1:0] fifoMem [0:FIFO_SZ-1];
   logic [DATA_W-1:0] rdReg;
   logic              pend;
   logic [PTR_W-1:0]  rdPtr;
   logic [PTR_W-1:0]  wrPtr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  occ;

   logic              readAccept;
   logic              writeAccept;
   logic              deq;
   logic              popFifo;
   logic              consumeReg;
   logic              pushFifo;
   logic              pendNext;
   logic              collide;
   logic [DATA_W-1:0] oldWord;
   logic [DATA_W-1:0] mergedWord;
   logic [DATA_W-1:0] readWord;
   logic              unusedClkGate;

   assign unusedClkGate = CLK_GATE;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_SZ - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Occupancy counts the response still sitting in rdReg as well as the queued ones.
   assign occ           = count + CNT_W'(pend);
   assign readReady     = RST_N && (occ < CNT_W'(OUT_DEPTH));
   assign writeReady    = RST_N;
   assign readDataReady = RST_N && ((count != '0) || pend);
   assign noPendingBool = !RST_N || (occ == '0);
   assign readData      = (count != '0) ? fifoMem[rdPtr] : rdReg;

   assign readAccept  = readEnable && readReady;
   assign writeAccept = writeEnable && writeReady;
   assign deq         = readDataEnable && readDataReady;
   assign popFifo     = deq && (count != '0);
   assign consumeReg  = deq && (count == '0) && pend;

   // rdReg drains into the queue when there is room (or room is being made this edge);
   // otherwise it holds, which only happens when the buffer is full and no read can land.
   assign pushFifo = pend && !consumeReg && ((count < CNT_W'(FIFO_D)) || popFifo);
   assign pendNext = readAccept || (pend && !consumeReg && !pushFifo);

   assign oldWord = mem[readAddr];
   assign collide = writeAccept && (readAddr == writeAddr);

   always_comb begin
      mergedWord = oldWord;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (writeMask[i]) begin
            mergedWord[i*8 +: 8] = writeData[i*8 +: 8];
         end
      end
   end

   assign readWord = ((WRITE_FIRST != 0) && collide) ? mergedWord : oldWord;

   // RAM contents are deliberately not reset.
   always_ff @(posedge CLK) begin
      if (writeAccept) begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (writeMask[i]) begin
               mem[writeAddr][i*8 +: 8] <= writeData[i*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (readAccept) begin
         rdReg <= readWord;
      end
   end

   always_ff @(posedge CLK) begin
      if (pushFifo) begin
         fifoMem[wrPtr] <= rdReg;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         pend  <= 1'b0;
         count <= '0;
         rdPtr <= '0;
         wrPtr <= '0;
      end else begin
         pend <= pendNext;
         if (pushFifo) begin
            wrPtr <= nextPtr(wrPtr);
         end
         if (popFifo) begin
            rdPtr <= nextPtr(rdPtr);
         end
         case ({pushFifo, popFifo})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_bram_buffered.sv
// Bench for bram_buffered: two instances (old-data and new-data collision policy) share stimulus
// and are checked every cycle against a queue-based response model plus directed literal checks.
module tb_bram_buffered;
   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 9;
   localparam int NUM_ROWS  = 512;
   localparam int OUT_DEPTH = 2;

   logic              CLK = 1'b0;
   logic              RST_N = 1'b0;
   logic              CLK_GATE = 1'b0;
   logic              readEnable = 1'b0;
   logic [ADDR_W-1:0] readAddr = '0;
   logic              readDataEnable = 1'b0;
   logic              writeEnable = 1'b0;
   logic [ADDR_W-1:0] writeAddr = '0;
   logic [DATA_W-1:0] writeData = '0;
   logic [3:0]        writeMask = '0;

   logic              readReady [2];
   logic              readDataReady [2];
   logic              writeReady [2];
   logic              noPendingBool [2];
   logic [DATA_W-1:0] readData [2];

   int nChecks = 0;
   int nFails  = 0;
   bit checkOn = 1'b0;

   always #5 CLK = ~CLK;

   bram_buffered #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_ROWS(NUM_ROWS),
                   .OUT_DEPTH(OUT_DEPTH), .WRITE_FIRST(0)) dutOld (
      .CLK(CLK), .RST_N(RST_N), .CLK_GATE(CLK_GATE),
      .readEnable(readEnable), .readAddr(readAddr), .readReady(readReady[0]),
      .readData(readData[0]), .readDataEnable(readDataEnable), .readDataReady(readDataReady[0]),
      .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
      .writeMask(writeMask), .writeReady(writeReady[0]), .noPendingBool(noPendingBool[0])
   );

   bram_buffered #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_ROWS(NUM_ROWS),
                   .OUT_DEPTH(OUT_DEPTH), .WRITE_FIRST(1)) dutNew (
      .CLK(CLK), .RST_N(RST_N), .CLK_GATE(CLK_GATE),
      .readEnable(readEnable), .readAddr(readAddr), .readReady(readReady[1]),
      .readData(readData[1]), .readDataEnable(readDataEnable), .readDataReady(readDataReady[1]),
      .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
      .writeMask(writeMask), .writeReady(writeReady[1]), .noPendingBool(noPendingBool[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Model: memory image plus the list of undelivered responses for each policy.
   logic [DATA_W-1:0] memM [0:NUM_ROWS-1];
   logic [DATA_W-1:0] q0[$];
   logic [DATA_W-1:0] q1[$];

   always @(posedge CLK) begin : model
      logic [DATA_W-1:0] oldW;
      logic [DATA_W-1:0] wrW;
      bit deqM;
      bit accM;
      if (!RST_N) begin
         q0.delete();
         q1.delete();
      end else begin
         deqM = readDataEnable && (q0.size() > 0);
         accM = readEnable && (q0.size() < OUT_DEPTH);
         wrW  = memM[writeAddr];
         for (int b = 0; b < 4; b++) begin
            if (writeMask[b]) wrW[b*8 +: 8] = writeData[b*8 +: 8];
         end
         if (deqM) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
         end
         if (accM) begin
            oldW = memM[readAddr];
            q0.push_back(oldW);
            q1.push_back((writeEnable && writeAddr == readAddr) ? wrW : oldW);
         end
         if (writeEnable) memM[writeAddr] = wrW;
      end
   end

   always @(negedge CLK) begin
      if (checkOn) begin
         for (int k = 0; k < 2; k++) begin
            check($sformatf("readReady%0d", k), 32'(readReady[k]),
                  32'(RST_N && (q0.size() < OUT_DEPTH)));
            check($sformatf("readDataReady%0d", k), 32'(readDataReady[k]),
                  32'(RST_N && (q0.size() > 0)));
            check($sformatf("writeReady%0d", k), 32'(writeReady[k]), 32'(RST_N));
            check($sformatf("noPendingBool%0d", k), 32'(noPendingBool[k]),
                  32'(!RST_N || (q0.size() == 0)));
            if (RST_N && q0.size() > 0) begin
               check($sformatf("readData%0d", k), readData[k], (k == 0) ? q0[0] : q1[0]);
            end
         end
      end
   end

   function automatic logic [31:0] initWord(input int a);
      return 32'h1000_0000 + 32'(a) * 32'h0000_0101;
   endfunction

   function automatic logic [31:0] streamWord(input int a);
      case (a)
         5:       return 32'h1122_3344;
         7:       return 32'hAABB_CC55;
         9:       return 32'hDEAD_BEEF;
         default: return initWord(a);
      endcase
   endfunction

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      RST_N   = 1'b1;
      checkOn = 1'b1;
      @(negedge CLK);
      check("reset readDataReady", 32'(readDataReady[0]), 32'd0);
      check("reset noPendingBool", 32'(noPendingBool[0]), 32'd1);

      for (int i = 0; i < 64; i++) begin
         writeEnable = 1'b1; writeAddr = ADDR_W'(i); writeData = initWord(i); writeMask = 4'hF;
         tick();
      end
      writeEnable = 1'b0;

      // Basic write then read, latency 1
      writeEnable = 1'b1; writeAddr = 9'd5; writeData = 32'h1122_3344; writeMask = 4'hF;
      tick();
      writeEnable = 1'b0; readEnable = 1'b1; readAddr = 9'd5; readDataEnable = 1'b1;
      @(negedge CLK);
      check("t1 not ready before accept", 32'(readDataReady[0]), 32'd0);
      tick();
      readEnable = 1'b0;
      @(negedge CLK);
      check("t1 ready after accept", 32'(readDataReady[0]), 32'd1);
      check("t1 data", readData[0], 32'h1122_3344);
      check("t1 pending", 32'(noPendingBool[0]), 32'd0);
      tick();
      readDataEnable = 1'b0;
      @(negedge CLK);
      check("t1 drained", 32'(readDataReady[0]), 32'd0);
      check("t1 noPending back", 32'(noPendingBool[0]), 32'd1);

      // Byte mask
      writeEnable = 1'b1; writeAddr = 9'd7; writeData = 32'hAABB_CCDD; writeMask = 4'hF;
      tick();
      writeData = 32'h0000_0055; writeMask = 4'h1;
      tick();
      writeEnable = 1'b0; readEnable = 1'b1; readAddr = 9'd7; readDataEnable = 1'b1;
      tick();
      readEnable = 1'b0;
      @(negedge CLK);
      check("t2 masked data", readData[0], 32'hAABB_CC55);
      tick();
      readDataEnable = 1'b0;

      // Backpressure with a two-entry buffer
      readEnable = 1'b1; readAddr = 9'd1;
      tick();
      readAddr = 9'd2;
      @(negedge CLK);
      check("t3 ready after first", 32'(readReady[0]), 32'd1);
      tick();
      readAddr = 9'd3;
      @(negedge CLK);
      check("t3 full", 32'(readReady[0]), 32'd0);
      check("t3 head1", readData[0], 32'h1000_0101);
      tick();
      @(negedge CLK);
      check("t3 still full", 32'(readReady[0]), 32'd0);
      readDataEnable = 1'b1;
      tick();
      readDataEnable = 1'b0;
      @(negedge CLK);
      check("t3 ready after dequeue", 32'(readReady[0]), 32'd1);
      check("t3 head2", readData[0], 32'h1000_0202);
      tick();
      readEnable = 1'b0; readDataEnable = 1'b1;
      @(negedge CLK);
      check("t3 head2 again", readData[0], 32'h1000_0202);
      tick();
      @(negedge CLK);
      check("t3 head3", readData[0], 32'h1000_0303);
      tick();
      readDataEnable = 1'b0;
      @(negedge CLK);
      check("t3 empty", 32'(noPendingBool[0]), 32'd1);

      // Same-address read/write collision
      writeEnable = 1'b1; writeAddr = 9'd9; writeData = 32'h0; writeMask = 4'hF;
      tick();
      writeData = 32'hDEAD_BEEF; readEnable = 1'b1; readAddr = 9'd9; readDataEnable = 1'b1;
      tick();
      writeEnable = 1'b0; readEnable = 1'b0;
      @(negedge CLK);
      check("t4 old-data policy", readData[0], 32'h0);
      check("t4 new-data policy", readData[1], 32'hDEAD_BEEF);
      tick();
      readEnable = 1'b1;
      tick();
      readEnable = 1'b0;
      @(negedge CLK);
      check("t4 reread old policy", readData[0], 32'hDEAD_BEEF);
      check("t4 reread new policy", readData[1], 32'hDEAD_BEEF);
      tick();
      readDataEnable = 1'b0;

      // Reset with two responses buffered; requests during reset are ignored
      readEnable = 1'b1; readAddr = 9'd1;
      tick();
      readAddr = 9'd2;
      tick();
      readEnable = 1'b0;
      @(negedge CLK);
      check("t5 buffered", 32'(readDataReady[0]), 32'd1);
      check("t5 pending", 32'(noPendingBool[0]), 32'd0);
      RST_N = 1'b0;
      writeEnable = 1'b1; writeAddr = 9'd7; writeData = 32'hFFFF_FFFF; writeMask = 4'hF;
      readEnable = 1'b1; readAddr = 9'd3;
      @(negedge CLK);
      check("t5 in reset readReady", 32'(readReady[0]), 32'd0);
      check("t5 in reset writeReady", 32'(writeReady[0]), 32'd0);
      check("t5 in reset readDataReady", 32'(readDataReady[0]), 32'd0);
      tick();
      RST_N = 1'b1; writeEnable = 1'b0; readEnable = 1'b0;
      @(negedge CLK);
      check("t5 after reset readDataReady", 32'(readDataReady[0]), 32'd0);
      check("t5 after reset noPending", 32'(noPendingBool[0]), 32'd1);
      readEnable = 1'b1; readAddr = 9'd7; readDataEnable = 1'b1;
      tick();
      readEnable = 1'b0;
      @(negedge CLK);
      check("t5 retained", readData[0], 32'hAABB_CC55);
      tick();
      readDataEnable = 1'b0;

      // Streaming: one response per cycle, no bubbles
      readDataEnable = 1'b1;
      for (int i = 0; i < 64; i++) begin
         readEnable = 1'b1; readAddr = ADDR_W'(i);
         tick();
         @(negedge CLK);
         check($sformatf("t6 valid %0d", i), 32'(readDataReady[0]), 32'd1);
         check($sformatf("t6 data %0d", i), readData[0], streamWord(i));
      end
      readEnable = 1'b0;
      tick();
      readDataEnable = 1'b0;
      @(negedge CLK);
      check("t6 drained", 32'(noPendingBool[0]), 32'd1);

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
